// File: rtl/rob_tagged_if.sv
// Port bundle of the tagged reorder buffer: allocation, ALU/LSU writeback,
// retire stream, mispredict redirect and occupancy.
interface rob_tagged_if #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [DATA_W-1:0] alloc_pc;
  logic [RD_W-1:0]   alloc_rd;
  logic [IDX_W-1:0]  alloc_idx;

  logic              alu_valid;
  logic [IDX_W-1:0]  alu_idx;
  logic [DATA_W-1:0] alu_data;
  logic [DATA_W-1:0] alu_jpc;

  logic              lsu_valid;
  logic [IDX_W-1:0]  lsu_idx;
  logic [DATA_W-1:0] lsu_data;
  logic [2:0]        lsu_kind;

  logic              commit_valid;
  logic [RD_W-1:0]   commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [DATA_W-1:0] commit_pc;

  logic              flush;
  logic [DATA_W-1:0] flush_pc;
  logic [IDX_W:0]    count;

  modport slave (
    input  alloc_valid, alloc_pc, alloc_rd,
    input  alu_valid, alu_idx, alu_data, alu_jpc,
    input  lsu_valid, lsu_idx, lsu_data, lsu_kind,
    output alloc_ready, alloc_idx,
    output commit_valid, commit_rd, commit_data, commit_pc,
    output flush, flush_pc, count
  );

  modport master (
    output alloc_valid, alloc_pc, alloc_rd,
    output alu_valid, alu_idx, alu_data, alu_jpc,
    output lsu_valid, lsu_idx, lsu_data, lsu_kind,
    input  alloc_ready, alloc_idx,
    input  commit_valid, commit_rd, commit_data, commit_pc,
    input  flush, flush_pc, count
  );
endinterface

// File: rtl/rob_tagged.sv
// Tagged reorder buffer: in-order allocate/retire, out-of-order ALU/LSU
// writeback by tag, and full drain with redirect on a mispredicted commit.
module rob_tagged #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic clk,
  input  logic rst,
  rob_tagged_if.slave bus
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  logic              valid_r [DEPTH];
  logic              done_r  [DEPTH];
  logic [DATA_W-1:0] pc_r    [DEPTH];
  logic [DATA_W-1:0] jpc_r   [DEPTH];
  logic [DATA_W-1:0] data_r  [DEPTH];
  logic [RD_W-1:0]   rd_r    [DEPTH];

  logic [IDX_W-1:0]  head_r;
  logic [IDX_W-1:0]  tail_r;
  logic [IDX_W:0]    count_r;

  logic              commit_valid_r;
  logic [RD_W-1:0]   commit_rd_r;
  logic [DATA_W-1:0] commit_data_r;
  logic [DATA_W-1:0] commit_pc_r;
  logic              flush_r;
  logic [DATA_W-1:0] flush_pc_r;

  logic              alloc_ready_s;
  logic              alloc_fire_s;
  logic              commit_s;
  logic              mispredict_s;

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw,
                                                 input logic [2:0] kind);
    case (kind)
      3'd0:    load_ext = {{(DATA_W-8){raw[7]}}, raw[7:0]};
      3'd1:    load_ext = {{(DATA_W-16){raw[15]}}, raw[15:0]};
      3'd2:    load_ext = raw;
      3'd3:    load_ext = {{(DATA_W-8){1'b0}}, raw[7:0]};
      3'd4:    load_ext = {{(DATA_W-16){1'b0}}, raw[15:0]};
      default: load_ext = '0;
    endcase
  endfunction

  assign alloc_ready_s    = (count_r < FULL_CNT) && !flush_r;
  assign alloc_fire_s     = bus.alloc_valid && alloc_ready_s;

  assign bus.alloc_ready  = alloc_ready_s;
  assign bus.alloc_idx    = tail_r;
  assign bus.count        = count_r;
  assign bus.commit_valid = commit_valid_r;
  assign bus.commit_rd    = commit_rd_r;
  assign bus.commit_data  = commit_data_r;
  assign bus.commit_pc    = commit_pc_r;
  assign bus.flush        = flush_r;
  assign bus.flush_pc     = flush_pc_r;

  // Retire decision for the head entry and mispredict detection.
  always_comb begin
    commit_s     = 1'b0;
    mispredict_s = 1'b0;
    if ((count_r != '0) && done_r[head_r]) begin
      commit_s     = 1'b1;
      mispredict_s = (jpc_r[head_r] != (pc_r[head_r] + DATA_W'(4)));
    end else begin
      commit_s     = 1'b0;
      mispredict_s = 1'b0;
    end
  end

  // Entry storage, pointers, occupancy and registered retire/redirect outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        done_r[i]  <= 1'b0;
        pc_r[i]    <= '0;
        jpc_r[i]   <= '0;
        data_r[i]  <= '0;
        rd_r[i]    <= '0;
      end
      head_r         <= '0;
      tail_r         <= '0;
      count_r        <= '0;
      commit_valid_r <= 1'b0;
      commit_rd_r    <= '0;
      commit_data_r  <= '0;
      commit_pc_r    <= '0;
      flush_r        <= 1'b0;
      flush_pc_r     <= '0;
    end else begin
      commit_valid_r <= commit_s;
      commit_rd_r    <= commit_s ? rd_r[head_r]   : '0;
      commit_data_r  <= commit_s ? data_r[head_r] : '0;
      commit_pc_r    <= commit_s ? pc_r[head_r]   : '0;
      flush_r        <= mispredict_s;
      flush_pc_r     <= mispredict_s ? jpc_r[head_r] : '0;

      if (mispredict_s) begin
        // Redirect drains everything, including this cycle's alloc/writebacks.
        for (int i = 0; i < DEPTH; i++) begin
          valid_r[i] <= 1'b0;
          done_r[i]  <= 1'b0;
        end
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= '0;
      end else begin
        if (bus.lsu_valid && valid_r[bus.lsu_idx]) begin
          done_r[bus.lsu_idx] <= 1'b1;
          data_r[bus.lsu_idx] <= load_ext(bus.lsu_data, bus.lsu_kind);
        end
        // Placed after the LSU update so the ALU wins on a shared tag.
        if (bus.alu_valid && valid_r[bus.alu_idx]) begin
          done_r[bus.alu_idx] <= 1'b1;
          data_r[bus.alu_idx] <= bus.alu_data;
          jpc_r[bus.alu_idx]  <= bus.alu_jpc;
        end
        if (alloc_fire_s) begin
          valid_r[tail_r] <= 1'b1;
          done_r[tail_r]  <= 1'b0;
          pc_r[tail_r]    <= bus.alloc_pc;
          jpc_r[tail_r]   <= bus.alloc_pc + DATA_W'(4);
          rd_r[tail_r]    <= bus.alloc_rd;
          tail_r          <= tail_r + IDX_W'(1);
        end
        if (commit_s) begin
          valid_r[head_r] <= 1'b0;
          done_r[head_r]  <= 1'b0;
          head_r          <= head_r + IDX_W'(1);
        end
        case ({alloc_fire_s, commit_s})
          2'b10:   count_r <= count_r + (IDX_W+1)'(1);
          2'b01:   count_r <= count_r - (IDX_W+1)'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule
